vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator with a built-in sync-alignment delay line. It produces horizontal/vertical counters, active-area pixel coordinates and frame/line markers for the pixel renderer. It also emits hsync/vsync/de delayed by a configurable number of clocks, so sync matches renderer pipeline latency without external bypass registers. It sits between the pixel clock domain root and the VGA pins, replacing the fixed 800x600 sync block.

---
 rtl/vga_pkg.sv | 18 +
 rtl/vga_delay_line.sv | 31 +++
 rtl/vga_timing_gen.sv | 126 ++++++++++++
 tb/tb_vga_timing_gen.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared phase encoding, default 800x600@60 timing and total-length helpers
package vga_pkg;
  typedef enum logic [1:0] {PH_SYNC, PH_BACK, PH_ACTIVE, PH_FRONT} phase_e;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BACK   = 88;
  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FRONT  = 40;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BACK   = 23;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FRONT  = 1;
  function automatic int h_total(int s, int b, int a, int f);
    return s + b + a + f;
  endfunction
  function automatic int v_total(int s, int b, int a, int f);
    return s + b + a + f;
  endfunction
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: enable-gated shift register with reset fill value; DEPTH=0 is a wire
module vga_delay_line
  import vga_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];
      // shift one stage per enabled clock; reset refills every stage with the inactive value
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else if (en) begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      assign dout = stage[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, phase FSMs, pixel coordinates and delayed syncs
// Optional VGA_TIMING_GEN_FRAME_CNT_EN adds a 16-bit frame counter output.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int CNT_W      = 11,
  parameter int SYNC_DELAY = 2,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             active,
  output logic             line_start,
  output logic             frame_start,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             de_o
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);
  localparam int H_TOT = h_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
  localparam int V_TOT = v_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
  localparam logic [CNT_W-1:0] H_E0  = CNT_W'(H_SYNC - 1);
  localparam logic [CNT_W-1:0] H_E1  = CNT_W'(H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] H_E2  = CNT_W'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] H_E3  = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_E0  = CNT_W'(V_SYNC - 1);
  localparam logic [CNT_W-1:0] V_E1  = CNT_W'(V_SYNC + V_BACK - 1);
  localparam logic [CNT_W-1:0] V_E2  = CNT_W'(V_SYNC + V_BACK + V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_E3  = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_OFS = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] V_OFS = CNT_W'(V_SYNC + V_BACK);

  function automatic phase_e next_ph(phase_e ph, logic [CNT_W-1:0] c,
                                     logic [CNT_W-1:0] e0, logic [CNT_W-1:0] e1,
                                     logic [CNT_W-1:0] e2, logic [CNT_W-1:0] e3);
    return (ph == PH_SYNC   && c == e0) ? PH_BACK   :
           (ph == PH_BACK   && c == e1) ? PH_ACTIVE :
           (ph == PH_ACTIVE && c == e2) ? PH_FRONT  :
           (ph == PH_FRONT  && c == e3) ? PH_SYNC   : ph;
  endfunction

  logic [CNT_W-1:0] hcnt, vcnt;
  phase_e           hph, vph, hph_n, vph_n;
  logic             h_wrap, v_wrap, on, first_px, hs_raw, vs_raw;

  assign h_wrap   = hcnt == H_E3;
  assign v_wrap   = vcnt == V_E3;
  assign on       = hph == PH_ACTIVE && vph == PH_ACTIVE;
  assign first_px = on && hcnt == H_OFS;

  // phase advance: horizontal every pixel, vertical only on the line wrap
  always_comb begin
    hph_n = next_ph(hph, hcnt, H_E0, H_E1, H_E2, H_E3);
    vph_n = h_wrap ? next_ph(vph, vcnt, V_E0, V_E1, V_E2, V_E3) : vph;
  end

  // raster counters and registered phase state, frozen while pix_en is low
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
      hph  <= PH_SYNC;
      vph  <= PH_SYNC;
    end else if (pix_en) begin
      hcnt <= h_wrap ? '0 : hcnt + 1'b1;
      vcnt <= h_wrap ? (v_wrap ? '0 : vcnt + 1'b1) : vcnt;
      hph  <= hph_n;
      vph  <= vph_n;
    end

  // coordinate/marker/raw sync registers; markers only pulse on enabled cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      active      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hs_raw      <= ~HS_POL;
      vs_raw      <= ~VS_POL;
    end else begin
      line_start  <= pix_en && first_px;
      frame_start <= pix_en && first_px && vcnt == V_OFS;
      if (pix_en) begin
        x      <= on ? hcnt - H_OFS : '0;
        y      <= on ? vcnt - V_OFS : '0;
        active <= on;
        hs_raw <= hph == PH_SYNC ? HS_POL : ~HS_POL;
        vs_raw <= vph == PH_SYNC ? VS_POL : ~VS_POL;
      end
    end

`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
  // frame counter steps on the same edge that raises frame_start
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) frame_cnt <= '0;
    else if (pix_en && first_px && vcnt == V_OFS) frame_cnt <= frame_cnt + 16'd1;
`endif

  vga_delay_line #(
    .WIDTH  (3),
    .DEPTH  (SYNC_DELAY),
    .RST_VAL({~HS_POL, ~VS_POL, 1'b0})
  ) u_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (pix_en),
    .din  ({hs_raw, vs_raw, active}),
    .dout ({hsync_o, vsync_o, de_o})
  );
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: two small-raster instances (delay 7 / active-low, delay 0 / active-high) vs position model
module tb_vga_timing_gen;
  localparam int DA = 7;
  localparam int DB = 0;
  int pa[8] = '{3, 2, 8, 2, 2, 1, 4, 1};
  int pb[8] = '{2, 3, 5, 1, 1, 2, 3, 2};

  typedef struct packed {
    logic act;
    logic [31:0] x, y;
    logic ls, fs, hs, vs;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, pix_en = 1'b0;
  logic [4:0] xa, ya;
  logic [3:0] xb, yb;
  logic act_a, ls_a, fs_a, hs_a, vs_a, de_a;
  logic act_b, ls_b, fs_b, hs_b, vs_b, de_b;
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
  logic [15:0] fc_a, fc_b;
`endif
  int total = 0, bad = 0;
  int k;
  exp_t ea, eb;
  logic [2:0] qa[$], qb[$];
  logic [2:0] da, db;
  logic [15:0] fca, fcb;

  always #5 clk = ~clk;

  vga_timing_gen #(.H_SYNC(3), .H_BACK(2), .H_ACTIVE(8), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1), .CNT_W(5),
    .SYNC_DELAY(DA), .HS_POL(1'b0), .VS_POL(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(xa), .y(ya), .active(act_a),
    .line_start(ls_a), .frame_start(fs_a), .hsync_o(hs_a), .vsync_o(vs_a), .de_o(de_a)
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    , .frame_cnt(fc_a)
`endif
  );

  vga_timing_gen #(.H_SYNC(2), .H_BACK(3), .H_ACTIVE(5), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(2), .V_ACTIVE(3), .V_FRONT(2), .CNT_W(4),
    .SYNC_DELAY(DB), .HS_POL(1'b1), .VS_POL(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(xb), .y(yb), .active(act_b),
    .line_start(ls_b), .frame_start(fs_b), .hsync_o(hs_b), .vsync_o(vs_b), .de_o(de_b)
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    , .frame_cnt(fc_b)
`endif
  );

  // expected registered outputs for the k-th enabled cycle after reset, from raster position
  function automatic exp_t ref_at(int n, int p[8], bit hp, bit vp);
    exp_t r;
    int ht = p[0] + p[1] + p[2] + p[3];
    int vt = p[4] + p[5] + p[6] + p[7];
    int pos = n % (ht * vt);
    int h = pos % ht;
    int v = pos / ht;
    int h0 = p[0] + p[1];
    int v0 = p[4] + p[5];
    r.act = h >= h0 && h < h0 + p[2] && v >= v0 && v < v0 + p[6];
    r.x = r.act ? 32'(h - h0) : 32'd0;
    r.y = r.act ? 32'(v - v0) : 32'd0;
    r.ls = r.act && h == h0;
    r.fs = r.ls && v == v0;
    r.hs = h < p[0] ? hp : !hp;
    r.vs = v < p[4] ? vp : !vp;
    return r;
  endfunction

  task automatic model_reset();
    k = 0;
    ea = '{act: 0, x: 0, y: 0, ls: 0, fs: 0, hs: 1, vs: 1};
    eb = '{act: 0, x: 0, y: 0, ls: 0, fs: 0, hs: 0, vs: 0};
    qa.delete();
    qb.delete();
    for (int i = 0; i < DA; i++) qa.push_back(3'b110);
    for (int i = 0; i < DB; i++) qb.push_back(3'b000);
    da = 3'b110;
    db = 3'b000;
    fca = 0;
    fcb = 0;
  endtask

  task automatic model_advance();
    ea = ref_at(k, pa, 1'b0, 1'b0);
    eb = ref_at(k, pb, 1'b1, 1'b1);
    k++;
    if (ea.fs) fca++;
    if (eb.fs) fcb++;
    qa.push_back({ea.hs, ea.vs, ea.act});
    qb.push_back({eb.hs, eb.vs, eb.act});
    if (qa.size() > DA + 1) void'(qa.pop_front());
    if (qb.size() > DB + 1) void'(qb.pop_front());
    da = qa[qa.size() - 1 - DA];
    db = qb[qb.size() - 1 - DB];
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_x", 32'(xa), ea.x);
    chk("a_y", 32'(ya), ea.y);
    chk("a_active", 32'(act_a), 32'(ea.act));
    chk("a_line_start", 32'(ls_a), 32'(ea.ls));
    chk("a_frame_start", 32'(fs_a), 32'(ea.fs));
    chk("a_delayed", 32'({hs_a, vs_a, de_a}), 32'(da));
    chk("b_x", 32'(xb), eb.x);
    chk("b_y", 32'(yb), eb.y);
    chk("b_active", 32'(act_b), 32'(eb.act));
    chk("b_line_start", 32'(ls_b), 32'(eb.ls));
    chk("b_frame_start", 32'(fs_b), 32'(eb.fs));
    chk("b_delayed", 32'({hs_b, vs_b, de_b}), 32'(db));
`ifdef VGA_TIMING_GEN_FRAME_CNT_EN
    chk("a_frame_cnt", 32'(fc_a), 32'(fca));
    chk("b_frame_cnt", 32'(fc_b), 32'(fcb));
`endif
  endtask

  task automatic step(input bit en);
    pix_en = en;
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (en) model_advance();
    else begin
      ea.ls = 0;
      ea.fs = 0;
      eb.ls = 0;
      eb.fs = 0;
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int guard;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) step(1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) step(1'b1);
    for (int i = 0; i < 200; i++) step(i[0] == 1'b0);
    for (int i = 0; i < 500; i++) step($urandom_range(0, 3) != 0);
    guard = 0;
    while (!(ea.act && ea.x == 4) && guard < 400) begin
      step(1'b1);
      guard++;
    end
    chk("midline_reach", 32'(guard < 400), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    for (int i = 0; i < 3; i++) step($urandom_range(0, 1) == 1);
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) step(1'b1);
    for (int i = 0; i < 600; i++) step($urandom_range(0, 1) == 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
